// File: rtl/adc733_pkg.sv
// adc733 shared package: sample/channel widths and output-buffer states.
// Used by the serial-interface stage and the frame averager.
package adc733_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int CH_W       = 3;
    localparam int NUM_CH_DEF = 6;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } buf_st_t;

endpackage

// File: rtl/adc733_frame_avg_if.sv
// adc733 frame output stream: valid/ready word bus toward the host path.
// master drives m_valid/m_data/m_chan/m_last, slave drives m_ready.
interface adc733_frame_avg_if;
    import adc733_pkg::*;

    logic                m_valid;
    logic                m_ready;
    logic [SAMPLE_W-1:0] m_data;
    logic [CH_W-1:0]     m_chan;
    logic                m_last;

    modport master (
        output m_valid, m_data, m_chan, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_chan, m_last,
        output m_ready
    );

endinterface

// File: rtl/adc733_ch_acc.sv
// adc733 per-channel accumulator: signed sum plus sample count.
// Ports: clk, rst_l, clr, add, din in; full, avg (average incl. din) out.
module adc733_ch_acc
    import adc733_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       clr,
    input  logic                       add,
    input  logic signed [SAMPLE_W-1:0] din,
    output logic                       full,
    output logic        [SAMPLE_W-1:0] avg
);

    localparam int AW = SAMPLE_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] sum;
    logic        [CW-1:0] cnt;

    assign ext  = AW'(din);
    assign sum  = add ? acc + ext : acc;
    assign full = (cnt == (CW'(1) << AVG_LOG2));
    // Upper slice of the sum is the floor-shifted average, so the
    // completing sample is already included on the loading edge.
    assign avg  = sum[AW-1:AVG_LOG2];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/adc733_frame_avg.sv
// adc733 frame averager: per-channel averaging, frame buffer, word stream.
// Ports: clk, rst_l, clear, sample_* in; m (master) stream; status out.
module adc733_frame_avg
    import adc733_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       clear,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_data,
    input  logic        [CH_W-1:0]     sample_channel,
    adc733_frame_avg_if.master         m,
    output logic                       overrun,
    output logic                       seq_err,
    output logic        [15:0]         frame_cnt
);

    logic [NUM_CH-1:0]   hit;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   add;
    logic [SAMPLE_W-1:0] avg  [NUM_CH];
    logic [SAMPLE_W-1:0] obuf [NUM_CH];
    logic [CH_W-1:0]     ptr;
    buf_st_t             st;
    buf_st_t             st_nxt;
    logic                done;
    logic                bad;
    logic                acc_clr;
    logic                vld;
    logic                hs;
    logic                is_last;
    logic                load;
    logic                ovr_set;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = sample_valid && (sample_channel == CH_W'(i));
    end

    assign add     = hit & ~full;
    // Frame completes when the accepted sample fills the last open channel.
    assign done    = (|add) && (&(full | add));
    assign bad     = sample_valid && (~(|hit) || (|(hit & full)));
    assign acc_clr = clear | done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_acc
        adc733_ch_acc #(.AVG_LOG2(AVG_LOG2)) u_acc (
            .clk   (clk),
            .rst_l (rst_l),
            .clr   (acc_clr),
            .add   (add[g]),
            .din   (sample_data),
            .full  (full[g]),
            .avg   (avg[g])
        );
    end

    assign vld     = (st == SEND);
    assign hs      = vld && m.m_ready;
    assign is_last = (ptr == CH_W'(NUM_CH - 1));

    always_comb begin
        st_nxt  = st;
        load    = 1'b0;
        ovr_set = 1'b0;
        unique case (st)
            EMPTY: begin
                if (done) begin
                    st_nxt = SEND;
                    load   = 1'b1;
                end
            end
            SEND: begin
                // Last-word handshake frees the buffer in the same cycle.
                if (done && hs && is_last) begin
                    load = 1'b1;
                end else begin
                    ovr_set = done;
                    if (hs && is_last)
                        st_nxt = EMPTY;
                end
            end
            default: st_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            st <= EMPTY;
        else if (clear)
            st <= EMPTY;
        else
            st <= st_nxt;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++)
                obuf[i] <= '0;
            ptr       <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            seq_err   <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++)
                obuf[i] <= '0;
            ptr       <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < NUM_CH; i++)
                    obuf[i] <= avg[i];
                ptr       <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (hs) begin
                ptr <= is_last ? '0 : ptr + CH_W'(1);
            end
            overrun <= overrun | ovr_set;
            seq_err <= seq_err | bad;
        end
    end

    assign m.m_valid = vld;
    assign m.m_data  = vld ? obuf[ptr] : '0;
    assign m.m_chan  = ptr;
    assign m.m_last  = vld && is_last;

endmodule

// File: tb/tb_adc733_frame_avg.sv
// adc733_frame_avg bench: directed frames with hand-computed averages.
// Covers nominal, extremes, backpressure, coincident load, seq, flush.
module tb_adc733_frame_avg;

    logic               clk = 1'b0;
    logic               rst_l = 1'b0;
    logic               clear = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_data = '0;
    logic        [2:0]  sample_channel = '0;
    logic               overrun;
    logic               seq_err;
    logic        [15:0] frame_cnt;

    int n_chk = 0;
    int n_err = 0;

    adc733_frame_avg_if mif ();

    adc733_frame_avg #(.NUM_CH(6), .AVG_LOG2(2)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .m              (mif.master),
        .overrun        (overrun),
        .seq_err        (seq_err),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] smp(input int kind, input int r,
                                        input int c);
        if (kind == 0) return 16'(16'h0100 * c + r);
        case (c)
            0:       return (r == 3) ? 16'hFFFE : 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] avgw(input int kind, input int c);
        if (kind == 0) return 16'(16'h0100 * c + 1);
        case (c)
            0:       return 16'hFFFE;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic strobe(input int ch, input logic [15:0] d);
        sample_valid   = 1'b1;
        sample_channel = 3'(ch);
        sample_data    = d;
        @(posedge clk);
        #1;
        sample_valid   = 1'b0;
    endtask

    task automatic feed(input int kind, input int n);
        int k = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 6; c++) begin
                if (k < n) strobe(c, smp(kind, r, c));
                k++;
            end
    endtask

    task automatic drain(input int kind, input string tag);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_v"}, 32'(mif.m_valid), 32'd1);
            chk({tag, "_d"}, 32'(mif.m_data), 32'(avgw(kind, i)));
            chk({tag, "_c"}, 32'(mif.m_chan), 32'(i));
            chk({tag, "_l"}, 32'(mif.m_last), 32'(i == 5));
            @(posedge clk);
            #1;
        end
        chk({tag, "_end"}, 32'(mif.m_valid), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        mif.m_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(mif.m_valid), 32'd0);
        chk("rst_data", 32'(mif.m_data), 32'd0);
        chk("rst_last", 32'(mif.m_last), 32'd0);
        chk("rst_flags", {30'd0, overrun, seq_err}, 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        feed(0, 23);
        chk("nom_early", 32'(mif.m_valid), 32'd0);
        strobe(5, smp(0, 3, 5));
        chk("nom_fcnt", 32'(frame_cnt), 32'd1);
        drain(0, "nom");

        feed(1, 24);
        chk("sgn_fcnt", 32'(frame_cnt), 32'd2);
        drain(1, "sgn");

        do_clear();
        mif.m_ready = 1'b0;
        feed(0, 24);
        feed(1, 24);
        chk("bp_ovr", 32'(overrun), 32'd1);
        chk("bp_fcnt", 32'(frame_cnt), 32'd1);
        chk("bp_hold_v", 32'(mif.m_valid), 32'd1);
        chk("bp_hold_d", 32'(mif.m_data), 32'h0001);
        chk("bp_hold_c", 32'(mif.m_chan), 32'd0);
        mif.m_ready = 1'b1;
        drain(0, "bp");

        do_clear();
        chk("clr_flags", {30'd0, overrun, seq_err}, 32'd0);
        mif.m_ready = 1'b0;
        feed(0, 24);
        feed(1, 23);
        mif.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("co_d", 32'(mif.m_data), 32'(avgw(0, i)));
            @(posedge clk);
            #1;
        end
        chk("co_last", 32'(mif.m_last), 32'd1);
        strobe(5, smp(1, 3, 5));
        chk("co_ovr", 32'(overrun), 32'd0);
        chk("co_fcnt", 32'(frame_cnt), 32'd2);
        drain(1, "co");

        do_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 6; c++) begin
                if (r == 3 && c == 3) begin
                    strobe(2, 16'h7777);
                    strobe(6, 16'h1234);
                end
                strobe(c, smp(0, r, c));
            end
        chk("seq_err", 32'(seq_err), 32'd1);
        chk("seq_ovr", 32'(overrun), 32'd0);
        drain(0, "seq");

        for (int pass = 0; pass < 2; pass++) begin
            strobe(7, 16'h0000);
            chk("fl_pre_seq", 32'(seq_err), 32'd1);
            feed(0, 24);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
            end
            chk("fl_ptr", 32'(mif.m_chan), 32'd3);
            mif.m_ready = 1'b0;
            strobe(0, 16'h4000);
            strobe(1, 16'h4000);
            if (pass == 0) begin
                #2;
                rst_l = 1'b0;
                #1;
            end else begin
                do_clear();
            end
            chk("fl_valid", 32'(mif.m_valid), 32'd0);
            chk("fl_chan", 32'(mif.m_chan), 32'd0);
            chk("fl_flags", {30'd0, overrun, seq_err}, 32'd0);
            chk("fl_fcnt", 32'(frame_cnt), 32'd0);
            if (pass == 0) begin
                @(negedge clk);
                rst_l = 1'b1;
                @(posedge clk);
                #1;
            end
            mif.m_ready = 1'b1;
            feed(0, 24);
            chk("fl_new_fcnt", 32'(frame_cnt), 32'd1);
            drain(0, "fl");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
